// File: rtl/xc_sched.sv
// xc_sched: periodic cross-correlation trigger with lag averaging and handshake watchdog
module xc_sched #(
  parameter int PERIOD   = 60000,
  parameter int TIMEOUT  = 600000,
  parameter int AVG_LOG2 = 2,
  parameter int LAG_W    = 6
) (
  input  logic             clk_60MHz,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clr_err,
  output logic             subsys_start,
  input  logic             subsys_done,
  input  logic [LAG_W-1:0] lag_diff,
  output logic [LAG_W-1:0] last_lag,
  output logic [LAG_W-1:0] avg_lag,
  output logic             avg_valid,
  output logic             busy,
  output logic             err_timeout
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_BUSY  = 3'd2;
  localparam logic [2:0] S_REL   = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam int CW = $clog2((PERIOD > TIMEOUT ? PERIOD : TIMEOUT) + 1);
  localparam int AW = LAG_W + AVG_LOG2;
  localparam logic [AVG_LOG2:0] NS = (AVG_LOG2+1)'(1) << AVG_LOG2;

  logic [2:0]        st_q, st_d;
  logic [CW-1:0]     tmr_q, tmr_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [AVG_LOG2:0] cnt_q, cnt_d;
  logic              start_q, start_d, avgv_q, avgv_d, err_q, err_d;
  logic [LAG_W-1:0]  last_q, last_d, avg_q, avg_d;

  // One timer serves as watchdog in BUSY and period counter in WAIT
  always_comb begin
    st_d    = st_q;
    tmr_d   = tmr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    start_d = start_q;
    last_d  = last_q;
    avg_d   = avg_q;
    avgv_d  = 1'b0;
    err_d   = clr_err ? 1'b0 : err_q;
    case (st_q)
      S_IDLE: if (run) begin
        st_d  = S_START;
        acc_d = '0;
        cnt_d = '0;
      end
      S_START: begin
        start_d = 1'b1;
        tmr_d   = CW'(TIMEOUT - 1);
        st_d    = S_BUSY;
      end
      S_BUSY: if (subsys_done) begin
        last_d  = lag_diff;
        acc_d   = acc_q + AW'(lag_diff);
        cnt_d   = cnt_q + (AVG_LOG2+1)'(1);
        start_d = 1'b0;
        st_d    = S_REL;
      end else if (tmr_q == '0) begin
        start_d = 1'b0;
        err_d   = 1'b1;
        st_d    = S_REL;
      end else begin
        tmr_d = tmr_q - CW'(1);
      end
      S_REL: if (!subsys_done) begin
        if (cnt_q == NS) begin
          avg_d  = LAG_W'(acc_q >> AVG_LOG2);
          avgv_d = 1'b1;
          acc_d  = '0;
          cnt_d  = '0;
        end
        tmr_d = run ? CW'(PERIOD - 1) : tmr_q;
        st_d  = run ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        st_d  = !run ? S_IDLE : (tmr_q == '0) ? S_START : S_WAIT;
        tmr_d = tmr_q - CW'(1);
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_60MHz or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= S_IDLE;
      tmr_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      last_q  <= '0;
      avg_q   <= '0;
      avgv_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      tmr_q   <= tmr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      last_q  <= last_d;
      avg_q   <= avg_d;
      avgv_q  <= avgv_d;
      err_q   <= err_d;
    end
  end

  assign subsys_start = start_q;
  assign last_lag     = last_q;
  assign avg_lag      = avg_q;
  assign avg_valid    = avgv_q;
  assign err_timeout  = err_q;
  assign busy         = st_q != S_IDLE;
endmodule

// File: tb/tb_xc_sched.sv
// tb_xc_sched: directed table-driven bench for xc_sched (PERIOD=8, TIMEOUT=20, AVG_LOG2=2)
module tb_xc_sched;
  logic       clk_60MHz = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       clr_err = 1'b0;
  logic       subsys_done = 1'b0;
  logic [5:0] lag_diff = '0;
  logic       subsys_start, avg_valid, busy, err_timeout;
  logic [5:0] last_lag, avg_lag;
  logic [5:0] exp_last = '0;
  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    bit         to;
    int         hold;
    logic [5:0] lag;
    bit         av;
    logic [5:0] avg;
  } row_t;

  row_t tab1[9];
  row_t tab2[4];

  xc_sched #(.PERIOD(8), .TIMEOUT(20), .AVG_LOG2(2), .LAG_W(6)) dut (
    .clk_60MHz(clk_60MHz), .rst_n(rst_n), .run(run), .clr_err(clr_err),
    .subsys_start(subsys_start), .subsys_done(subsys_done), .lag_diff(lag_diff),
    .last_lag(last_lag), .avg_lag(avg_lag), .avg_valid(avg_valid),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk_60MHz = ~clk_60MHz;

  task automatic tick();
    @(posedge clk_60MHz);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Entered in the first cycle subsys_start is high; leaves at the next such cycle
  task automatic run_row(input row_t r);
    int n;
    if (r.to) begin
      n = 0;
      while (subsys_start && n < 40) begin tick(); n++; end
      chk("timeout_cycles", n, 20);
      chk("timeout_err", err_timeout, 1);
      chk("timeout_last", last_lag, exp_last);
      subsys_done = 1'b1;
      lag_diff = 6'd63;
      repeat (3) tick();
      chk("late_done_last", last_lag, exp_last);
      chk("late_done_start", subsys_start, 0);
      subsys_done = 1'b0;
      clr_err = 1'b1;
    end else begin
      repeat (4) tick();
      subsys_done = 1'b1;
      lag_diff = r.lag;
      tick();
      exp_last = r.lag;
      chk("done_start_drop", subsys_start, 0);
      chk("last_lag", last_lag, exp_last);
      lag_diff = 6'd63;
      for (int i = 1; i < r.hold; i++) begin
        tick();
        chk("held_done_start", subsys_start, 0);
      end
      chk("held_last", last_lag, exp_last);
      subsys_done = 1'b0;
    end
    tick();
    clr_err = 1'b0;
    chk("avg_valid", avg_valid, r.av);
    if (r.av) chk("avg_lag", avg_lag, r.avg);
    chk("err_state", err_timeout, 0);
    n = 0;
    while (!subsys_start && n < 20) begin tick(); n++; end
    chk("start_gap", n, 9);
  endtask

  initial begin
    tab1[0] = '{0, 1, 6'd10, 0, 6'd0};
    tab1[1] = '{0, 1, 6'd11, 0, 6'd0};
    tab1[2] = '{0, 1, 6'd12, 0, 6'd0};
    tab1[3] = '{0, 1, 6'd14, 1, 6'd11};
    tab1[4] = '{0, 1, 6'd20, 0, 6'd0};
    tab1[5] = '{0, 1, 6'd21, 0, 6'd0};
    tab1[6] = '{1, 1, 6'd0,  0, 6'd0};
    tab1[7] = '{0, 5, 6'd22, 0, 6'd0};
    tab1[8] = '{0, 1, 6'd23, 1, 6'd21};
    tab2[0] = '{0, 1, 6'd4, 0, 6'd0};
    tab2[1] = '{0, 1, 6'd4, 0, 6'd0};
    tab2[2] = '{0, 1, 6'd4, 0, 6'd0};
    tab2[3] = '{0, 1, 6'd8, 1, 6'd5};
    repeat (2) tick();
    chk("rst_start", subsys_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_avgv", avg_valid, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_last", last_lag, 0);
    chk("rst_avg", avg_lag, 0);
    rst_n = 1'b1;
    tick();
    run = 1'b1;
    tick();
    chk("c1_start", subsys_start, 0);
    chk("c1_busy", busy, 1);
    tick();
    chk("c2_start", subsys_start, 1);
    foreach (tab1[i]) run_row(tab1[i]);
    run = 1'b0;
    repeat (3) begin
      tick();
      chk("run_drop_hold", subsys_start, 1);
    end
    subsys_done = 1'b1;
    lag_diff = 6'd30;
    tick();
    exp_last = 6'd30;
    chk("drop_done_start", subsys_start, 0);
    chk("drop_done_last", last_lag, exp_last);
    subsys_done = 1'b0;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_avgv", avg_valid, 0);
    tick();
    chk("idle_start", subsys_start, 0);
    run = 1'b1;
    tick();
    chk("restart_busy", busy, 1);
    tick();
    chk("restart_start", subsys_start, 1);
    foreach (tab2[i]) run_row(tab2[i]);
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_start", subsys_start, 0);
    chk("arst_busy", busy, 0);
    chk("arst_last", last_lag, 0);
    chk("arst_avg", avg_lag, 0);
    chk("arst_avgv", avg_valid, 0);
    run = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);
    run = 1'b1;
    tick();
    chk("post_rst_c1", subsys_start, 0);
    tick();
    chk("post_rst_c2", subsys_start, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
